// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: holds the PC, reads instruction memory over
// req/ack and hands each word to the decoder over valid/stall.
module busca_instrucao #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clock,
   input  logic        resetCPU,
   input  logic [31:0] novoEndereco,
   output logic [31:0] endereco,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        stall,
   output logic [31:0] instrucao,
   output logic [31:0] instrucao_pc,
   output logic        instrucao_valida,
   output logic [31:0] contador_instrucoes
);

   typedef enum logic [1:0] {
      INICIO,
      BUSCA,
      ENTREGA
   } estado_t;

   estado_t estado;

   assign mem_req  = (estado == BUSCA);
   assign mem_addr = endereco;

   always_ff @(posedge clock) begin
      if (resetCPU) begin
         estado              <= INICIO;
         endereco            <= RESET_PC;
         instrucao           <= 32'd0;
         instrucao_pc        <= 32'd0;
         instrucao_valida    <= 1'b0;
         contador_instrucoes <= 32'd0;
      end else begin
         unique case (estado)
            INICIO: begin
               estado <= BUSCA;
            end
            BUSCA: begin
               if (mem_ack) begin
                  instrucao        <= mem_rdata;
                  instrucao_pc     <= endereco;
                  instrucao_valida <= 1'b1;
                  estado           <= ENTREGA;
               end
            end
            ENTREGA: begin
               // accept: PC follows the adder, count wraps naturally
               if (!stall) begin
                  endereco            <= novoEndereco;
                  instrucao_valida    <= 1'b0;
                  contador_instrucoes <= contador_instrucoes + 32'd1;
                  estado              <= BUSCA;
               end
            end
            default: begin
               estado <= INICIO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: a scoreboard queue holds the word and PC
// expected for each acked fetch until the decoder side presents it.
module tb_busca_instrucao;

   logic        clock = 1'b0;
   logic        resetCPU;
   logic [31:0] novoEndereco;
   logic [31:0] endereco;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [31:0] instrucao;
   logic [31:0] instrucao_pc;
   logic        instrucao_valida;
   logic [31:0] contador_instrucoes;

   always #5 clock = ~clock;

   busca_instrucao #(.RESET_PC(32'd0)) dut (
      .clock               (clock),
      .resetCPU            (resetCPU),
      .novoEndereco        (novoEndereco),
      .endereco            (endereco),
      .mem_req             (mem_req),
      .mem_addr            (mem_addr),
      .mem_ack             (mem_ack),
      .mem_rdata           (mem_rdata),
      .stall               (stall),
      .instrucao           (instrucao),
      .instrucao_pc        (instrucao_pc),
      .instrucao_valida    (instrucao_valida),
      .contador_instrucoes (contador_instrucoes)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } esperado_t;

   esperado_t sb[$];
   esperado_t e;
   int errors = 0;
   int checks = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_cnt;

   task automatic tick();
      @(negedge clock);
   endtask

   // drive an ack for the current PC and record what should come back
   task automatic give_ack(input logic [31:0] w);
      mem_ack   = 1'b1;
      mem_rdata = w;
      sb.push_back({w, exp_pc});
      tick();
      mem_ack   = 1'b0;
   endtask

   task automatic test_reset();
      resetCPU = 1'b1;
      mem_ack  = 1'b1;
      tick();
      tick();
      mem_ack = 1'b0;
      exp_pc  = 32'd0;
      exp_cnt = 32'd0;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_req got=%b want=0", mem_req);
      end
      checks++;
      if (endereco !== 32'd0) begin
         errors++;
         $display("FAIL rst_pc got=%h want=0", endereco);
      end
      checks++;
      if (instrucao_valida !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid got=%b want=0", instrucao_valida);
      end
      checks++;
      if (instrucao !== 32'd0 || instrucao_pc !== 32'd0) begin
         errors++;
         $display("FAIL rst_instr got=%h/%h want=0/0", instrucao, instrucao_pc);
      end
      checks++;
      if (contador_instrucoes !== 32'd0) begin
         errors++;
         $display("FAIL rst_cnt got=%h want=0", contador_instrucoes);
      end
   endtask

   task automatic test_zero_wait();
      resetCPU     = 1'b0;
      novoEndereco = 32'd1;
      stall        = 1'b0;
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL zw_req got=%b/%h want=1/0", mem_req, mem_addr);
      end
      give_ack(32'h2008_0005);
      checks++;
      if (instrucao_valida !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL zw_valid got=%b req=%b want=1/0", instrucao_valida, mem_req);
      end else begin
         e = sb.pop_front();
         checks++;
         if (instrucao !== e.instr || instrucao_pc !== e.pc) begin
            errors++;
            $display("FAIL zw_word got=%h@%h want=%h@%h", instrucao, instrucao_pc, e.instr, e.pc);
         end
      end
      tick();
      exp_pc = 32'd1;
      exp_cnt++;
      checks++;
      if (endereco !== exp_pc || contador_instrucoes !== exp_cnt) begin
         errors++;
         $display("FAIL zw_next got=%h cnt=%0d want=%h cnt=%0d", endereco, contador_instrucoes, exp_pc, exp_cnt);
      end
   endtask

   task automatic test_wait_states();
      novoEndereco = 32'd4;
      give_ack(32'hAAAA_0001);
      e = sb.pop_front();
      checks++;
      if (instrucao !== e.instr || instrucao_pc !== e.pc) begin
         errors++;
         $display("FAIL ws_pre got=%h@%h want=%h@%h", instrucao, instrucao_pc, e.instr, e.pc);
      end
      tick();
      exp_pc = 32'd4;
      exp_cnt++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 32'd4 || instrucao_valida !== 1'b0) begin
            errors++;
            $display("FAIL ws_hold%0d got=%b/%h v=%b want=1/4 v=0", i, mem_req, mem_addr, instrucao_valida);
         end
         if (i < 3) tick();
      end
      give_ack(32'hBEEF_0004);
      stall   = 1'b1;
      mem_ack = 1'b1;
      checks++;
      if (instrucao_valida !== 1'b1) begin
         errors++;
         $display("FAIL ws_valid got=%b want=1", instrucao_valida);
      end else begin
         e = sb.pop_front();
         checks++;
         if (instrucao !== e.instr || instrucao_pc !== e.pc) begin
            errors++;
            $display("FAIL ws_word got=%h@%h want=%h@%h", instrucao, instrucao_pc, e.instr, e.pc);
         end
      end
      mem_rdata = 32'hDEAD_DEAD;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (instrucao !== 32'hBEEF_0004 || instrucao_valida !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL ws_ackignored got=%h v=%b req=%b want=beef0004 v=1 req=0", instrucao, instrucao_valida, mem_req);
      end
      stall        = 1'b0;
      novoEndereco = 32'd8;
      tick();
      exp_pc = 32'd8;
      exp_cnt++;
   endtask

   task automatic test_stall();
      give_ack(32'h1234_5678);
      e = sb.pop_front();
      novoEndereco = 32'h40;
      stall        = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (endereco !== exp_pc || instrucao !== e.instr || instrucao_pc !== e.pc || contador_instrucoes !== exp_cnt || instrucao_valida !== 1'b1) begin
            errors++;
            $display("FAIL stall%0d got=%h %h@%h cnt=%0d want=%h %h@%h cnt=%0d", i, endereco, instrucao, instrucao_pc, contador_instrucoes, exp_pc, e.instr, e.pc, exp_cnt);
         end
         tick();
      end
      stall = 1'b0;
      tick();
      exp_pc = 32'h40;
      exp_cnt++;
      checks++;
      if (endereco !== exp_pc || contador_instrucoes !== exp_cnt || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL stall_rel got=%h cnt=%0d want=%h cnt=%0d", endereco, contador_instrucoes, exp_pc, exp_cnt);
      end
   endtask

   task automatic test_jump();
      novoEndereco = 32'h100;
      give_ack(32'h0800_0040);
      e = sb.pop_front();
      tick();
      exp_pc = 32'h100;
      exp_cnt++;
      checks++;
      if (mem_addr !== 32'h100 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL jmp_addr got=%h want=100", mem_addr);
      end
      novoEndereco = 32'h101;
      give_ack(32'h8C09_0000);
      e = sb.pop_front();
      checks++;
      if (instrucao_pc !== e.pc || instrucao !== e.instr) begin
         errors++;
         $display("FAIL jmp_pc got=%h@%h want=%h@%h", instrucao, instrucao_pc, e.instr, e.pc);
      end
      tick();
      exp_pc = 32'h101;
      exp_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      for (int i = 0; i < 6; i++) begin
         w            = $urandom();
         novoEndereco = exp_pc + 32'd1;
         give_ack(w);
         e = sb.pop_front();
         checks++;
         if (instrucao_valida !== 1'b1 || instrucao !== e.instr || instrucao_pc !== e.pc) begin
            errors++;
            $display("FAIL b2b%0d got=%h@%h v=%b want=%h@%h", i, instrucao, instrucao_pc, instrucao_valida, e.instr, e.pc);
         end
         tick();
         exp_pc = exp_pc + 32'd1;
         exp_cnt++;
      end
      checks++;
      if (contador_instrucoes !== exp_cnt || endereco !== exp_pc) begin
         errors++;
         $display("FAIL b2b_cnt got=%0d pc=%h want=%0d pc=%h", contador_instrucoes, endereco, exp_cnt, exp_pc);
      end
   endtask

   task automatic test_reset_mid();
      resetCPU  = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_0000;
      tick();
      exp_pc  = 32'd0;
      exp_cnt = 32'd0;
      checks++;
      if (instrucao_valida !== 1'b0 || endereco !== 32'd0 || contador_instrucoes !== 32'd0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rstbusca got v=%b pc=%h cnt=%0d req=%b want 0/0/0/0", instrucao_valida, endereco, contador_instrucoes, mem_req);
      end
      resetCPU = 1'b0;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (instrucao_valida !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL rst_inicioack got v=%b req=%b addr=%h want 0/1/0", instrucao_valida, mem_req, mem_addr);
      end
      novoEndereco = 32'h200;
      give_ack(32'h2008_0005);
      e = sb.pop_front();
      checks++;
      if (instrucao !== e.instr || instrucao_pc !== e.pc) begin
         errors++;
         $display("FAIL rst_refetch got=%h@%h want=%h@%h", instrucao, instrucao_pc, e.instr, e.pc);
      end
      resetCPU = 1'b1;
      tick();
      resetCPU = 1'b0;
      checks++;
      if (endereco !== 32'd0 || contador_instrucoes !== 32'd0 || instrucao_valida !== 1'b0) begin
         errors++;
         $display("FAIL rst_entrega got pc=%h cnt=%0d v=%b want 0/0/0", endereco, contador_instrucoes, instrucao_valida);
      end
      tick();
   endtask

   task automatic test_counter_wrap();
      novoEndereco = 32'd1;
      give_ack(32'h0000_0020);
      e     = sb.pop_front();
      stall = 1'b1;
      dut.contador_instrucoes = 32'hFFFF_FFFF;
      tick();
      checks++;
      if (contador_instrucoes !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_pre got=%h want=ffffffff", contador_instrucoes);
      end
      stall = 1'b0;
      tick();
      checks++;
      if (contador_instrucoes !== 32'd0 || endereco !== 32'd1) begin
         errors++;
         $display("FAIL wrap got=%h pc=%h want=0 pc=1", contador_instrucoes, endereco);
      end
   endtask

   initial begin
      resetCPU     = 1'b1;
      novoEndereco = 32'd0;
      mem_ack      = 1'b0;
      mem_rdata    = 32'd0;
      stall        = 1'b0;
      exp_pc       = 32'd0;
      exp_cnt      = 32'd0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_jump();
      test_back_to_back();
      test_reset_mid();
      test_counter_wrap();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_left got=%0d want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
